// File: rtl/layer_output_collector.sv
// rtl/layer_output_collector.sv - captures one activation per neuron lane, then streams them out and tracks their argmax
module layer_output_collector #(
  parameter int numNeurons = 10,
  parameter int dataWidth  = 8,
  parameter int idxWidth   = $clog2(numNeurons)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic [numNeurons*dataWidth-1:0] laneData,
  input  logic [numNeurons-1:0]           laneValid,
  output logic [dataWidth-1:0]            dataOut,
  output logic                            dataOutValid,
  input  logic                            dataOutReady,
  output logic [idxWidth-1:0]             dataOutIndex,
  output logic                            layerDone,
  output logic [idxWidth-1:0]             maxIndex,
  output logic                            overrun
);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_STREAM,
    S_DONE
  } state_e;

  // The counter only ever wraps through this compare, never by overflow.
  localparam logic [idxWidth-1:0] LastIdx = idxWidth'(numNeurons - 1);

  state_e                  state_q;
  logic [numNeurons-1:0]   mask_q;
  logic [numNeurons-1:0]   prev_valid_q;
  logic [dataWidth-1:0]    lane_buf_q [numNeurons];
  logic [idxWidth-1:0]     cnt_q;
  logic [dataWidth-1:0]    run_max_q;
  logic [idxWidth-1:0]     run_idx_q;
  logic [dataWidth-1:0]    data_q;
  logic                    valid_q;
  logic                    done_q;
  logic [idxWidth-1:0]     max_idx_q;
  logic                    over_q;

  logic [numNeurons-1:0]   lane_rise;
  logic                    lane_dup;
  logic                    transfer;
  logic                    new_max;
  logic [idxWidth-1:0]     cnt_inc;

  assign transfer = valid_q & dataOutReady;
  // data_q always holds buf[cnt] while streaming, so it is the value being transferred.
  assign new_max  = data_q > run_max_q;
  assign cnt_inc  = cnt_q + idxWidth'(1);

  // Rising-edge detect per lane; an edge is a protocol violation if the lane is already
  // captured or if the collector is not currently collecting.
  always_comb begin
    lane_rise = laneValid & ~prev_valid_q;
    if (state_q == S_COLLECT) begin
      lane_dup = |(lane_rise & mask_q);
    end else begin
      lane_dup = |lane_rise;
    end
  end

  // Capture, stream and argmax state machine; all outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_COLLECT;
      mask_q       <= '0;
      prev_valid_q <= '0;
      cnt_q        <= '0;
      run_max_q    <= '0;
      run_idx_q    <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      max_idx_q    <= '0;
      over_q       <= 1'b0;
      for (int i = 0; i < numNeurons; i++) begin
        lane_buf_q[i] <= '0;
      end
    end else begin
      prev_valid_q <= laneValid;
      done_q       <= 1'b0;
      if (clear) begin
        // Abort the frame; captured data and the last argmax are deliberately kept.
        state_q <= S_COLLECT;
        mask_q  <= '0;
        cnt_q   <= '0;
        valid_q <= 1'b0;
        over_q  <= 1'b0;
      end else begin
        if (lane_dup) begin
          over_q <= 1'b1;
        end
        unique case (state_q)
          S_COLLECT: begin
            for (int i = 0; i < numNeurons; i++) begin
              if (lane_rise[i] && !mask_q[i]) begin
                lane_buf_q[i] <= laneData[i*dataWidth +: dataWidth];
                mask_q[i]     <= 1'b1;
              end
            end
            // Registered all-captured check: a full mask never admits new captures,
            // so buf[0] is already stable when it is loaded here.
            if (&mask_q) begin
              state_q   <= S_STREAM;
              valid_q   <= 1'b1;
              cnt_q     <= '0;
              data_q    <= lane_buf_q[0];
              run_max_q <= '0;
              run_idx_q <= '0;
            end
          end
          S_STREAM: begin
            if (transfer) begin
              // Strictly greater replaces, so ties keep the lowest index.
              if (new_max) begin
                run_max_q <= data_q;
                run_idx_q <= cnt_q;
              end
              if (cnt_q == LastIdx) begin
                state_q   <= S_DONE;
                valid_q   <= 1'b0;
                cnt_q     <= '0;
                done_q    <= 1'b1;
                max_idx_q <= new_max ? cnt_q : run_idx_q;
              end else begin
                cnt_q  <= cnt_inc;
                data_q <= lane_buf_q[cnt_inc];
              end
            end
          end
          S_DONE: begin
            mask_q  <= '0;
            state_q <= S_COLLECT;
          end
          default: begin
            state_q <= S_COLLECT;
          end
        endcase
      end
    end
  end

  assign dataOut      = data_q;
  assign dataOutValid = valid_q;
  assign dataOutIndex = cnt_q;
  assign layerDone    = done_q;
  assign maxIndex     = max_idx_q;
  assign overrun      = over_q;

endmodule

// File: tb/tb_layer_output_collector.sv
// tb/tb_layer_output_collector.sv - directed and randomized checks of layer_output_collector against a frame-level model
module tb_layer_output_collector;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  localparam int P_COLLECT = 0;
  localparam int P_STREAM  = 1;
  localparam int P_DONE    = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           clear;
  logic [N*W-1:0] laneData;
  logic [N-1:0]   laneValid;
  logic [W-1:0]   dataOut;
  logic           dataOutValid;
  logic           dataOutReady;
  logic [IW-1:0]  dataOutIndex;
  logic           layerDone;
  logic [IW-1:0]  maxIndex;
  logic           overrun;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  layer_output_collector #(
    .numNeurons(N),
    .dataWidth (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .laneData    (laneData),
    .laneValid   (laneValid),
    .dataOut     (dataOut),
    .dataOutValid(dataOutValid),
    .dataOutReady(dataOutReady),
    .dataOutIndex(dataOutIndex),
    .layerDone   (layerDone),
    .maxIndex    (maxIndex),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: which lanes hold a value, the captured values, and where the
  // collector is in the frame. Expected outputs are read straight from these.
  int           m_phase;
  int           m_cnt;
  int           m_maxidx;
  bit           m_done;
  bit           m_over;
  logic [N-1:0] m_mask;
  logic [N-1:0] m_prev;
  logic [N-1:0] m_rises;
  logic [W-1:0] m_buf [N];
  bit           m_full;

  function automatic int frame_argmax();
    int best = 0;
    for (int i = 1; i < N; i++) begin
      if (m_buf[i] > m_buf[best]) best = i;
    end
    return best;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = P_COLLECT; m_cnt = 0; m_maxidx = 0; m_done = 0; m_over = 0;
      m_mask = '0; m_prev = '0;
      for (int i = 0; i < N; i++) m_buf[i] = '0;
    end else begin
      m_rises = laneValid & ~m_prev;
      m_prev  = laneValid;
      m_done  = 0;
      if (clear) begin
        m_phase = P_COLLECT; m_mask = '0; m_cnt = 0; m_over = 0;
      end else begin
        case (m_phase)
          P_COLLECT: begin
            m_full = &m_mask;
            for (int i = 0; i < N; i++) begin
              if (m_rises[i]) begin
                if (m_mask[i]) m_over = 1;
                else begin
                  m_buf[i]  = laneData[i*W +: W];
                  m_mask[i] = 1'b1;
                end
              end
            end
            if (m_full) begin m_phase = P_STREAM; m_cnt = 0; end
          end
          P_STREAM: begin
            if (|m_rises) m_over = 1;
            if (dataOutReady) begin
              if (m_cnt == N - 1) begin
                m_phase = P_DONE; m_done = 1; m_cnt = 0; m_maxidx = frame_argmax();
              end else m_cnt++;
            end
          end
          default: begin
            if (|m_rises) m_over = 1;
            m_mask  = '0;
            m_phase = P_COLLECT;
          end
        endcase
      end
    end
  end

  // Compare every cycle, half a period away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dataOutValid", 32'(dataOutValid), 32'(m_phase == P_STREAM));
      check("layerDone", 32'(layerDone), 32'(m_done));
      check("maxIndex", 32'(maxIndex), 32'(m_maxidx));
      check("overrun", 32'(overrun), 32'(m_over));
      if (m_phase == P_STREAM) begin
        check("dataOut", 32'(dataOut), 32'(m_buf[m_cnt]));
        check("dataOutIndex", 32'(dataOutIndex), 32'(m_cnt));
      end
    end
  end

  logic [W-1:0] xq[$];
  always @(negedge clk) begin
    if (dataOutValid && dataOutReady) xq.push_back(dataOut);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input int d);
    laneValid[i]       = 1'b1;
    laneData[i*W +: W] = d[W-1:0];
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!dataOutValid && n < 20) begin tick(); n++; end
    check(name, 32'(dataOutValid), 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!layerDone && n < 40) begin tick(); n++; end
    check(name, 32'(layerDone), 1);
  endtask

  initial begin
    bit [3:0] pat;
    int k;
    clear = 0; laneData = '0; laneValid = '0; dataOutReady = 0;
    #1 reset = 0;
    repeat (3) tick();
    reset = 1;
    chk_en = 1;
    check("rst_valid", 32'(dataOutValid), 0);
    check("rst_data", 32'(dataOut), 0);
    check("rst_index", 32'(dataOutIndex), 0);
    check("rst_done", 32'(layerDone), 0);
    check("rst_maxidx", 32'(maxIndex), 0);
    check("rst_overrun", 32'(overrun), 0);

    // 1: staggered capture, 2-cycle latency, tie keeps the lower index
    dataOutReady = 1; tick();
    set_lane(0, 5); tick();
    set_lane(1, 9); set_lane(2, 9); tick();
    tick();
    set_lane(3, 1); tick();
    check("t1_not_yet", 32'(dataOutValid), 0);
    tick();
    check("t1_first_valid", 32'(dataOutValid), 1);
    check("t1_d0", 32'(dataOut), 5);
    tick(); check("t1_d1", 32'(dataOut), 9); check("t1_i1", 32'(dataOutIndex), 1);
    tick(); check("t1_d2", 32'(dataOut), 9);
    tick(); check("t1_d3", 32'(dataOut), 1); check("t1_i3", 32'(dataOutIndex), 3);
    tick(); check("t1_done", 32'(layerDone), 1); check("t1_maxidx", 32'(maxIndex), 1);

    // 2: backpressure pattern 1,0,0,1
    dataOutReady = 0; laneValid = '0; tick();
    set_lane(0, 'h40); set_lane(1, 'h11); set_lane(2, 'h22); set_lane(3, 'h7F);
    xq.delete();
    wait_valid("t2_start");
    pat = 4'b1001; k = 0;
    while (!layerDone && k < 40) begin dataOutReady = pat[k % 4]; tick(); k++; end
    check("t2_done", 32'(layerDone), 1);
    check("t2_count", 32'(xq.size()), 4);
    if (xq.size() == 4) begin
      check("t2_x0", 32'(xq[0]), 'h40); check("t2_x1", 32'(xq[1]), 'h11);
      check("t2_x2", 32'(xq[2]), 'h22); check("t2_x3", 32'(xq[3]), 'h7F);
    end
    check("t2_maxidx", 32'(maxIndex), 3);

    // 3: lane 2 level-high never recaptures; an edge during STREAM is an overrun
    dataOutReady = 0;
    check("t3_over_pre", 32'(overrun), 0);
    laneValid[0] = 0; laneValid[1] = 0; laneValid[3] = 0; tick();
    set_lane(0, 'h10); set_lane(1, 'h20); set_lane(3, 'h30);
    repeat (6) tick();
    check("t3_no_recapture", 32'(dataOutValid), 0);
    laneValid[2] = 0; tick();
    set_lane(2, 'hAA);
    xq.delete();
    wait_valid("t3_start");
    laneValid[2] = 0; tick();
    set_lane(2, 'hFF); tick();
    check("t3_overrun", 32'(overrun), 1);
    dataOutReady = 1;
    wait_done("t3_done");
    check("t3_count", 32'(xq.size()), 4);
    if (xq.size() == 4) check("t3_lane2", 32'(xq[2]), 'hAA);
    check("t3_maxidx", 32'(maxIndex), 2);

    // 4: clear after two transfers
    laneValid = '0; tick();
    set_lane(0, 1); set_lane(1, 2); set_lane(2, 3); set_lane(3, 4);
    wait_valid("t4_start");
    tick(); tick();
    check("t4_idx", 32'(dataOutIndex), 2);
    clear = 1; dataOutReady = 0; tick();
    clear = 0;
    check("t4_valid", 32'(dataOutValid), 0);
    check("t4_nodone", 32'(layerDone), 0);
    check("t4_overrun", 32'(overrun), 0);
    check("t4_maxidx", 32'(maxIndex), 2);

    // 5: asynchronous reset mid-STREAM, then a full frame from the held lanes
    laneValid = '0; tick();
    set_lane(0, 7); set_lane(1, 3); set_lane(2, 8); set_lane(3, 8);
    wait_valid("t5_start");
    dataOutReady = 1; tick();
    dataOutReady = 0; laneValid[0] = 0; tick();
    laneValid[0] = 1; tick();
    check("t5_overrun_pre", 32'(overrun), 1);
    @(posedge clk); #3 reset = 0; #1;
    check("t5_rst_valid", 32'(dataOutValid), 0);
    check("t5_rst_done", 32'(layerDone), 0);
    check("t5_rst_maxidx", 32'(maxIndex), 0);
    check("t5_rst_overrun", 32'(overrun), 0);
    tick(); tick();
    reset = 1; dataOutReady = 1;
    wait_valid("t5_restart");
    wait_done("t5_done");
    check("t5_maxidx", 32'(maxIndex), 2);

    // 6: all lanes rise together with value 0
    laneValid = '0; tick();
    for (int i = 0; i < N; i++) set_lane(i, 0);
    wait_valid("t6_start");
    check("t6_d0", 32'(dataOut), 0);
    wait_done("t6_done");
    check("t6_maxidx", 32'(maxIndex), 0);

    // Randomized traffic against the model
    laneValid = '0; tick();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) laneValid[i] = ~laneValid[i];
      end
      laneData     = $urandom;
      dataOutReady = ($urandom_range(0, 3) != 0);
      clear        = ($urandom_range(0, 39) == 0);
      tick();
    end
    clear = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
